// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: arbitrates two register-transaction requesters onto one
// byte-level SPI master engine. Each transaction is one command byte
// {we, 5'b0, addr} followed by len+1 data bytes, framed by ss_n with
// GAP_CYCLES of setup before the first byte and hold after the last.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   req*/we*/addr*/len*/wdata*    per-requester transaction request
//   grant                         one-hot current owner, 2'b00 when idle
//   done0, done1                  one-cycle completion pulse per requester
//   rdata                         read data of the last completed read
//   ss_n                          SPI slave select, active low
//   m_start, m_tx_data            byte start pulse and byte to send
//   m_done, m_rx_data             byte finished pulse and received byte
module spi_xfer_arbiter #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [1:0]  len0,
  input  logic [1:0]  len1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  grant,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        ss_n,
  output logic        m_start,
  output logic [7:0]  m_tx_data,
  input  logic        m_done,
  input  logic [7:0]  m_rx_data
);

  localparam logic [7:0] GapInit = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {StIdle, StSetup, StCmd, StData, StHold, StFinish} state_e;

  state_e      state_q;
  logic        we_q;
  logic [1:0]  addr_q;
  logic [1:0]  len_q;
  logic [31:0] wdata_q;
  logic [1:0]  idx_q;
  logic [7:0]  gap_q;
  logic        last_q;  // index of the requester served last

  logic        pick1;
  logic        done_acc;
  logic [1:0]  idx_nxt;
  logic [7:0]  wr_byte_nxt;

  // Requester 1 wins when alone, or on contention when 0 was served last.
  assign pick1       = req1 && (!req0 || !last_q);
  // A completion in the same cycle as our own start pulse cannot be ours.
  assign done_acc    = m_done && !m_start;
  assign idx_nxt     = idx_q + 2'd1;
  assign wr_byte_nxt = wdata_q[{idx_nxt, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= 2'd0;
      len_q     <= 2'd0;
      wdata_q   <= 32'd0;
      idx_q     <= 2'd0;
      gap_q     <= 8'd0;
      last_q    <= 1'b1;
      grant     <= 2'b00;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= 32'd0;
      ss_n      <= 1'b1;
      m_start   <= 1'b0;
      m_tx_data <= 8'd0;
    end else begin
      m_start <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            we_q    <= pick1 ? we1    : we0;
            addr_q  <= pick1 ? addr1  : addr0;
            len_q   <= pick1 ? len1   : len0;
            wdata_q <= pick1 ? wdata1 : wdata0;
            grant   <= pick1 ? 2'b10  : 2'b01;
            idx_q   <= 2'd0;
            ss_n    <= 1'b0;
            gap_q   <= GapInit;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q == 8'd1) begin
            m_start   <= 1'b1;
            m_tx_data <= {we_q, 5'b00000, addr_q};
            state_q   <= StCmd;
          end
        end
        StCmd: begin
          if (done_acc) begin
            idx_q     <= 2'd0;
            m_start   <= 1'b1;
            m_tx_data <= we_q ? wdata_q[7:0] : 8'h00;
            state_q   <= StData;
          end
        end
        StData: begin
          if (done_acc) begin
            if (!we_q) begin
              rdata[{idx_q, 3'b000} +: 8] <= m_rx_data;
            end
            idx_q <= idx_nxt;
            if (idx_q == len_q) begin
              gap_q   <= GapInit;
              state_q <= StHold;
            end else begin
              m_start   <= 1'b1;
              m_tx_data <= we_q ? wr_byte_nxt : 8'h00;
            end
          end
        end
        StHold: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q == 8'd1) begin
            ss_n    <= 1'b1;
            done0   <= grant[0];
            done1   <= grant[1];
            state_q <= StFinish;
          end
        end
        StFinish: begin
          grant   <= 2'b00;
          last_q  <= grant[1];
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter. Two requesters and a byte engine are
// emulated; a transaction-level model predicts the winner, the byte stream,
// the setup/hold framing, the done pulse and rdata.
module tb_spi_xfer_arbiter;

  localparam int unsigned GAP = 3;

  logic        clk, reset;
  logic        req0, req1, we0, we1;
  logic [1:0]  addr0, addr1, len0, len1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  grant;
  logic        done0, done1, ss_n, m_start, m_done;
  logic [31:0] rdata;
  logic [7:0]  m_tx_data, m_rx_data;

  spi_xfer_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .grant(grant), .done0(done0), .done1(done1), .rdata(rdata),
    .ss_n(ss_n), .m_start(m_start), .m_tx_data(m_tx_data),
    .m_done(m_done), .m_rx_data(m_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model state.
  // phase: 0 idle, 1 grant expected, 2 setup/bytes, 3 hold/finish, 4 idle gap
  int          phase = 0;
  int          last_own = 1;
  int          owner, total, nseen, ndone, setup_cnt, hold_cnt, busy_cycles;
  int          txn_count = 0;
  logic        cur_we;
  logic [7:0]  exp_bytes [0:4];
  logic [31:0] m_rdata = 32'd0;
  bit          pending = 0;
  int          wait_cnt = 0;
  bit          aborted = 0;
  bit          drop0, drop1;
  logic [7:0]  rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] onehot(input int o);
    return (o == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic predict();
    logic [1:0]  a, l;
    logic [31:0] wd;
    if (phase == 0 && (req0 || req1)) begin
      owner  = (req0 && req1) ? ((last_own == 1) ? 0 : 1) : (req0 ? 0 : 1);
      cur_we = owner ? we1 : we0;
      a      = owner ? addr1 : addr0;
      l      = owner ? len1 : len0;
      wd     = owner ? wdata1 : wdata0;
      total  = int'(l) + 2;
      exp_bytes[0] = {cur_we, 5'b00000, a};
      for (int i = 0; i < 4; i++) exp_bytes[i+1] = cur_we ? wd[8*i +: 8] : 8'h00;
      nseen = 0; ndone = 0; setup_cnt = 0; hold_cnt = 0; busy_cycles = 0;
      pending = 0;
      phase = 1;
    end
  endtask

  task automatic raise(input int i);
    if (i == 0) begin
      req0 = 1; we0 = 1'($urandom); addr0 = 2'($urandom); len0 = 2'($urandom);
      wdata0 = $urandom;
    end else begin
      req1 = 1; we1 = 1'($urandom); addr1 = 2'($urandom); len1 = 2'($urandom);
      wdata1 = $urandom;
    end
  endtask

  initial begin
    int cycles = 0;
    reset = 0; m_done = 0; m_rx_data = 8'h00;
    // Directed opening: write from 0 and read from 1, both pending from reset.
    req0 = 1; we0 = 1; addr0 = 2'd2; len0 = 2'd1; wdata0 = 32'h0000_BEEF;
    req1 = 1; we1 = 0; addr1 = 2'd0; len1 = 2'd3; wdata1 = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_grant", grant, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_tx", m_tx_data, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", {done1, done0}, 0);
    reset = 1;
    predict();

    while (!(txn_count >= 14 && aborted)) begin
      @(negedge clk);
      cycles++;
      if (cycles > 20000) begin
        chk("run_timeout", 1, 0);
        break;
      end
      if (phase != 0) busy_cycles++;
      if (busy_cycles > 300) begin
        chk("xfer_timeout", busy_cycles, 300);
        break;
      end

      // Reset in the middle of the data phase, right after the second m_done.
      if (txn_count >= 8 && !aborted && phase == 2 && ndone == 2) begin
        reset = 0; m_done = 0;
        #1;
        chk("abort_ss_n", ss_n, 1);
        chk("abort_grant", grant, 0);
        chk("abort_m_start", m_start, 0);
        chk("abort_tx", m_tx_data, 0);
        chk("abort_rdata", rdata, 0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("abort_quiet", {m_start, done1, done0}, 0);
        end
        reset = 1;
        aborted = 1; phase = 0; last_own = 1; pending = 0; m_rdata = 32'd0;
        predict();
        continue;
      end

      drop0 = 0; drop1 = 0;
      chk("grant_legal", 32'(grant != 2'b11), 1);

      // Model checks against the state as it stood at this edge.
      case (phase)
        0: chk("idle_quiet", {grant, ss_n, done1, done0}, {2'b00, 1'b1, 2'b00});
        1: begin
          chk("grant_owner", grant, onehot(owner));
          chk("setup_ss_n", ss_n, 0);
          setup_cnt = 1;
          phase = 2;
        end
        2: begin
          chk("xfer_done_low", {done1, done0}, 0);
          if (m_start) begin
            if (nseen >= total) chk("extra_start", nseen, total - 1);
            else chk("tx_byte", m_tx_data, exp_bytes[nseen]);
            if (nseen == 0) chk("setup_gap", setup_cnt, GAP);
            nseen++;
          end else if (nseen == 0) begin
            setup_cnt++;
            chk("setup_ss_n", ss_n, 0);
          end else if (pending) begin
            chk("tx_stable", m_tx_data, exp_bytes[nseen-1]);
          end
        end
        3: begin
          hold_cnt++;
          chk("hold_start", m_start, 0);
          if (hold_cnt <= GAP) begin
            chk("hold_ss_n", ss_n, 0);
            chk("hold_done", {done1, done0}, 0);
          end else begin
            chk("done_pulse", {done1, done0}, onehot(owner));
            chk("finish_ss_n", ss_n, 1);
            chk("finish_grant", grant, onehot(owner));
            chk("start_count", nseen, total);
            chk("rdata", rdata, m_rdata);
            if (txn_count == 1) chk("directed_read", rdata, 32'h4433_2211);
            if (owner == 0) begin req0 = 0; drop0 = 1; end
            else begin req1 = 0; drop1 = 1; end
            last_own = owner;
            txn_count++;
            phase = 4;
          end
        end
        default: begin
          chk("gap_idle", {grant, ss_n, done1, done0}, {2'b00, 1'b1, 2'b00});
          phase = 0;
        end
      endcase

      // Byte engine, with spurious completions where they must be ignored.
      m_done = 0;
      m_rx_data = 8'($urandom);
      if (phase == 2 && m_start) begin
        pending = 1;
        wait_cnt = $urandom_range(0, 2);
        m_done = ($urandom_range(0, 3) == 0);
      end else if (pending) begin
        if (wait_cnt == 0) begin
          rx = (txn_count < 2) ? 8'(17 * ndone) : 8'($urandom);
          m_done = 1; m_rx_data = rx; pending = 0;
          if (ndone >= 1 && !cur_we) m_rdata[8*(ndone-1) +: 8] = rx;
          ndone++;
          if (ndone == total) begin
            phase = 3; hold_cnt = 0;
          end
        end else begin
          wait_cnt--;
        end
      end else if (phase != 2 || nseen == 0) begin
        m_done = ($urandom_range(0, 2) == 0);
      end

      // Requesters: new random requests, and churn on latched inputs.
      if (txn_count >= 2) begin
        if (!req0 && !drop0 && $urandom_range(0, 3) == 0) raise(0);
        if (!req1 && !drop1 && $urandom_range(0, 3) == 0) raise(1);
        if ((phase == 2 || phase == 3) && $urandom_range(0, 4) == 0) begin
          if (owner == 0) begin
            we0 = 1'($urandom); addr0 = 2'($urandom); len0 = 2'($urandom); wdata0 = $urandom;
          end else begin
            we1 = 1'($urandom); addr1 = 2'($urandom); len1 = 2'($urandom); wdata1 = $urandom;
          end
        end
      end

      predict();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
